// File: rtl/flexbus_master.sv
// FlexBus initiator: turns single-beat local requests into ALE/CS/RW/AD bus cycles.
// Optional macro FLEXBUS_MASTER_TURNAROUND_EN adds a dead TURN cycle after every read.
module flexbus_master #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FB_BASE     = 32'h6000_0000
) (
    input  logic        FB_CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_RW,
    input  logic [27:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        FB_ALE,
    output logic        FB_CS,
    output logic        FB_RW,
    inout  wire  [31:0] FB_AD,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_END  = 3'd3,
        S_TURN = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        ad_oe;
    logic [31:0] ad_out;
    logic [31:0] wdata_q;
    logic [31:0] bus_addr;

    // Byte-lane bits are forced to zero so every cycle addresses a full word.
    assign bus_addr  = FB_BASE | {4'h0, REQ_ADDR[27:2], REQ_ADDR[1:0] & 2'b00};
    assign FB_AD     = ad_oe ? ad_out : 32'hzzzz_zzzz;
    assign dbg_state = state;

    // Request handshake: a request transfers on a rising edge where REQ_VALID and
    // REQ_READY are both high; REQ_READY is registered and only high in IDLE, so
    // REQ_* may change freely at any other time without effect.
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'h0;
            FB_ALE    <= 1'b0;
            FB_CS     <= 1'b1;
            FB_RW     <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= 32'h0;
            wdata_q   <= 32'h0;
            wait_cnt  <= 4'h0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        state     <= S_ADDR;
                        REQ_READY <= 1'b0;
                        FB_ALE    <= 1'b1;
                        FB_RW     <= REQ_RW;
                        ad_out    <= bus_addr;
                        ad_oe     <= 1'b1;
                        wdata_q   <= REQ_WDATA;
                    end else begin
                        REQ_READY <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state    <= S_DATA;
                    FB_ALE   <= 1'b0;
                    FB_CS    <= 1'b0;
                    wait_cnt <= 4'(WAIT_STATES);
                    ad_out   <= wdata_q;
                    ad_oe    <= ~FB_RW;
                end
                S_DATA: begin
                    if (wait_cnt == 4'h0) begin
                        if (FB_RW) begin
                            RSP_RDATA <= FB_AD;
                        end
                        FB_CS     <= 1'b1;
                        RSP_VALID <= 1'b1;
                        state     <= S_END;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_END: begin
                    // Write data stays on the bus through END for responder hold time.
                    ad_oe <= 1'b0;
                    FB_RW <= 1'b1;
`ifdef FLEXBUS_MASTER_TURNAROUND_EN
                    if (FB_RW) begin
                        state <= S_TURN;
                    end else begin
                        state     <= S_IDLE;
                        REQ_READY <= 1'b1;
                    end
`else
                    state     <= S_IDLE;
                    REQ_READY <= 1'b1;
`endif
                end
                S_TURN: begin
                    state     <= S_IDLE;
                    REQ_READY <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
